// File: rtl/ftdi_fifo_responder.sv
// Device-side model of an FTDI 245-style parallel FIFO port: RX/TX byte FIFOs behind rd/wr strobes.
// Optional build macro FTDI_ECHO_EN: every wr byte loops back into the RX buffer and no TX buffer exists.
module ftdi_fifo_responder #(
  parameter int DEPTH     = 16,
  parameter int RD_LAT    = 2,
  parameter int PRECHARGE = 2
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       rd,
  input  logic       wr,
  input  logic [7:0] adbus_in,
  output logic       rxf,
  output logic       txe,
  output logic [7:0] adbus_out,
  output logic       adbus_oe,
  input  logic [7:0] host_din,
  input  logic       host_din_valid,
  output logic       host_din_ready,
  output logic [7:0] host_dout,
  output logic       host_dout_valid,
  input  logic       host_dout_ready,
  output logic       proto_err
);
  localparam int         AW       = $clog2(DEPTH);
  localparam int         PW       = AW + 1;
  localparam logic [2:0] RD_LOAD  = 3'(RD_LAT - 1);
  localparam logic [2:0] PRE_LOAD = 3'(PRECHARGE - 1);

  typedef enum logic [1:0] {R_IDLE, R_WAIT, R_DRIVE, R_PRE} r_state_t;
  typedef enum logic [1:0] {W_IDLE, W_ACTIVE, W_PRE} w_state_t;

  function automatic logic is_full(input logic [AW:0] wp, input logic [AW:0] rp);
    return (wp[AW] != rp[AW]) && (wp[AW-1:0] == rp[AW-1:0]);
  endfunction

  // Bits [1:0] form the synchronizer; bit 2 is the delayed copy used for edge detection.
  logic [2:0] rd_sync, wr_sync;
  logic [7:0] adbus_in_q;
  logic       rd_fall, rd_rise, wr_fall, wr_rise, both_low;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      rd_sync    <= 3'b111;
      wr_sync    <= 3'b111;
      adbus_in_q <= '0;
    end else begin
      // NOTE: state is always updated with <= so every flop samples pre-edge values.
      rd_sync    <= {rd_sync[1:0], rd};
      wr_sync    <= {wr_sync[1:0], wr};
      adbus_in_q <= adbus_in;
    end
  end

  assign rd_fall  = rd_sync[2] & ~rd_sync[1];
  assign rd_rise  = ~rd_sync[2] & rd_sync[1];
  assign wr_fall  = wr_sync[2] & ~wr_sync[1];
  assign wr_rise  = ~wr_sync[2] & wr_sync[1];
  assign both_low = ~rd_sync[1] & ~wr_sync[1];

  // RX buffer (host -> FPGA)
  logic [7:0]  rx_mem [DEPTH];
  logic [AW:0] rx_wp, rx_rp, rx_wp_nx, rx_rp_nx;
  logic        rx_push, rx_pop, rx_full, rx_empty_nx, rx_full_nx, host_push;
  logic [7:0]  rx_wdata;

  assign host_push   = host_din_valid && host_din_ready;
  assign rx_full     = is_full(rx_wp, rx_rp);
  assign rx_wp_nx    = rx_wp + PW'(rx_push);
  assign rx_rp_nx    = rx_rp + PW'(rx_pop);
  assign rx_empty_nx = (rx_wp_nx == rx_rp_nx);
  assign rx_full_nx  = is_full(rx_wp_nx, rx_rp_nx);

  // NOTE: storage arrays carry no reset; the pointers alone define what is valid.
  always_ff @(posedge clock) begin
    if (rx_push) rx_mem[rx_wp[AW-1:0]] <= rx_wdata;
  end

  // Read and write FSMs
  r_state_t   r_state, r_nx;
  w_state_t   w_state, w_nx;
  logic [2:0] r_cnt, r_cnt_nx, w_cnt, w_cnt_nx;
  logic       oe_nx, r_err, w_err, w_push, tgt_full_nx;
  logic [7:0] out_nx;

  always_comb begin
    // NOTE: every output of this block gets a default first, so no path can infer a latch.
    r_nx     = r_state;
    r_cnt_nx = r_cnt;
    oe_nx    = adbus_oe;
    out_nx   = adbus_out;
    rx_pop   = 1'b0;
    r_err    = 1'b0;
    unique case (r_state)
      R_IDLE:
        if (rd_fall) begin
          if (!rxf) begin
            r_nx     = R_WAIT;
            r_cnt_nx = RD_LOAD;
          end else begin
            r_err = 1'b1;
          end
        end
      R_WAIT:
        if (rd_rise) begin
          rx_pop   = 1'b1;
          r_err    = 1'b1;
          r_nx     = R_PRE;
          r_cnt_nx = PRE_LOAD;
        end else if (r_cnt == 3'd0) begin
          oe_nx  = 1'b1;
          out_nx = rx_mem[rx_rp[AW-1:0]];
          r_nx   = R_DRIVE;
        end else begin
          r_cnt_nx = r_cnt - 3'd1;
        end
      R_DRIVE:
        if (rd_rise) begin
          rx_pop   = 1'b1;
          oe_nx    = 1'b0;
          r_nx     = R_PRE;
          r_cnt_nx = PRE_LOAD;
        end
      R_PRE:
        if (r_cnt == 3'd0) r_nx = R_IDLE;
        else               r_cnt_nx = r_cnt - 3'd1;
      default: r_nx = R_IDLE;
    endcase
  end

  always_comb begin
    w_nx     = w_state;
    w_cnt_nx = w_cnt;
    w_push   = 1'b0;
    w_err    = 1'b0;
    unique case (w_state)
      W_IDLE:
        if (wr_fall) begin
          if (!txe) w_nx  = W_ACTIVE;
          else      w_err = 1'b1;
        end
      W_ACTIVE:
        if (wr_rise) begin
          w_push   = 1'b1;
          w_nx     = W_PRE;
          w_cnt_nx = PRE_LOAD;
        end
      W_PRE:
        if (w_cnt == 3'd0) w_nx = W_IDLE;
        else               w_cnt_nx = w_cnt - 3'd1;
      default: w_nx = W_IDLE;
    endcase
  end

`ifdef FTDI_ECHO_EN
  // Echoed bytes wait in a one-entry holding register; host pushes win the RX write port.
  logic       echo_pend, echo_pend_nx, echo_go, unused_dout_ready;
  logic [7:0] echo_data;

  assign echo_go           = echo_pend && !host_push && !rx_full;
  assign echo_pend_nx      = (echo_pend && !echo_go) || w_push;
  assign rx_push           = host_push || echo_go;
  assign rx_wdata          = host_push ? host_din : echo_data;
  assign tgt_full_nx       = rx_full_nx || echo_pend_nx;
  assign host_dout         = 8'h00;
  assign host_dout_valid   = 1'b0;
  assign unused_dout_ready = host_dout_ready;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      echo_pend <= 1'b0;
      echo_data <= '0;
    end else begin
      echo_pend <= echo_pend_nx;
      if (w_push) echo_data <= adbus_in_q;
    end
  end
`else
  // TX buffer (FPGA -> host); host_dout is registered from the next-state head.
  logic [7:0]  tx_mem [DEPTH];
  logic [AW:0] tx_wp, tx_rp, tx_wp_nx, tx_rp_nx;
  logic        tx_pop;
  logic [7:0]  tx_head_nx;

  assign rx_push     = host_push;
  assign rx_wdata    = host_din;
  assign tx_pop      = host_dout_valid && host_dout_ready;
  assign tx_wp_nx    = tx_wp + PW'(w_push);
  assign tx_rp_nx    = tx_rp + PW'(tx_pop);
  assign tgt_full_nx = is_full(tx_wp_nx, tx_rp_nx);
  assign tx_head_nx  = (w_push && (tx_rp_nx[AW-1:0] == tx_wp[AW-1:0])) ? adbus_in_q
                                                                       : tx_mem[tx_rp_nx[AW-1:0]];

  always_ff @(posedge clock) begin
    if (w_push) tx_mem[tx_wp[AW-1:0]] <= adbus_in_q;
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      tx_wp           <= '0;
      tx_rp           <= '0;
      host_dout       <= '0;
      host_dout_valid <= 1'b0;
    end else begin
      tx_wp           <= tx_wp_nx;
      tx_rp           <= tx_rp_nx;
      host_dout       <= tx_head_nx;
      host_dout_valid <= (tx_wp_nx != tx_rp_nx);
    end
  end
`endif

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_state        <= R_IDLE;
      w_state        <= W_IDLE;
      r_cnt          <= '0;
      w_cnt          <= '0;
      rx_wp          <= '0;
      rx_rp          <= '0;
      rxf            <= 1'b1;
      txe            <= 1'b1;
      adbus_oe       <= 1'b0;
      adbus_out      <= '0;
      proto_err      <= 1'b0;
      host_din_ready <= 1'b0;
    end else begin
      r_state        <= r_nx;
      w_state        <= w_nx;
      r_cnt          <= r_cnt_nx;
      w_cnt          <= w_cnt_nx;
      rx_wp          <= rx_wp_nx;
      rx_rp          <= rx_rp_nx;
      rxf            <= (r_nx == R_IDLE) ? rx_empty_nx : (r_nx == R_PRE);
      txe            <= (w_nx == W_IDLE) ? tgt_full_nx : (w_nx == W_PRE);
      adbus_oe       <= oe_nx;
      adbus_out      <= out_nx;
      proto_err      <= proto_err | r_err | w_err | both_low;
      host_din_ready <= !rx_full_nx;
    end
  end
endmodule

// File: tb/tb_ftdi_fifo_responder.sv
// Self-checking bench for ftdi_fifo_responder: directed steps plus random traffic against queue models.
module tb_ftdi_fifo_responder;
  localparam int DEPTH = 16;

  logic       clock = 1'b0;
  logic       reset = 1'b0;
  logic       rd = 1'b1, wr = 1'b1;
  logic [7:0] adbus_in = '0, host_din = '0;
  logic       host_din_valid = 1'b0, host_dout_ready = 1'b0;
  logic       rxf, txe, adbus_oe, host_din_ready, host_dout_valid, proto_err;
  logic [7:0] adbus_out, host_dout;

  int         checks = 0;
  int         failures = 0;
  logic [7:0] rx_q[$];
  logic [7:0] tx_q[$];
  bit         oe_seen;

  ftdi_fifo_responder #(.DEPTH(DEPTH), .RD_LAT(2), .PRECHARGE(2)) dut (
    .clock(clock), .reset(reset), .rd(rd), .wr(wr), .adbus_in(adbus_in),
    .rxf(rxf), .txe(txe), .adbus_out(adbus_out), .adbus_oe(adbus_oe),
    .host_din(host_din), .host_din_valid(host_din_valid), .host_din_ready(host_din_ready),
    .host_dout(host_dout), .host_dout_valid(host_dout_valid),
    .host_dout_ready(host_dout_ready), .proto_err(proto_err)
  );

  always #5 clock = ~clock;

  initial begin
    #500000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic do_reset();
    rd = 1'b1; wr = 1'b1; host_din_valid = 1'b0; host_dout_ready = 1'b0;
    reset = 1'b1;
    repeat (2) tick();
    check("rst_rxf", rxf, 1);
    check("rst_txe", txe, 1);
    check("rst_oe", adbus_oe, 0);
    check("rst_out", adbus_out, 0);
    check("rst_perr", proto_err, 0);
    check("rst_din_ready", host_din_ready, 0);
    check("rst_dout_valid", host_dout_valid, 0);
    reset = 1'b0;
    rx_q.delete();
    tx_q.delete();
    tick();
    check("post_rst_txe", txe, 0);
    check("post_rst_din_ready", host_din_ready, 1);
  endtask

  task automatic host_push(input logic [7:0] b);
    check("push_ready", host_din_ready, 1);
    host_din = b; host_din_valid = 1'b1;
    tick();
    host_din_valid = 1'b0;
    rx_q.push_back(b);
    check("push_rxf", rxf, 0);
  endtask

  // rd low until the bus is driven plus two more cycles, then release and watch precharge.
  task automatic rd_pulse();
    logic [7:0] exp;
    bit seen;
    exp = rx_q.pop_front();
    rd = 1'b0; seen = 1'b0;
    for (int n = 0; n < 6 && !seen; n++) begin tick(); seen = adbus_oe; end
    check("rd_oe_rise", seen, 1);
    check("rd_data", adbus_out, exp);
    check("rd_rxf_drive", rxf, 0);
    repeat (2) tick();
    check("rd_oe_hold", adbus_oe, 1);
    rd = 1'b1; seen = 1'b0;
    for (int n = 0; n < 6 && !seen; n++) begin tick(); seen = !adbus_oe; end
    check("rd_oe_fall", seen, 1);
    check("rd_pre0", rxf, 1);
    tick();
    check("rd_pre1", rxf, 1);
    tick();
    check("rd_idle_rxf", rxf, rx_q.size() == 0);
  endtask

  task automatic wr_pulse(input logic [7:0] b);
    bit accept;
    accept = (tx_q.size() < DEPTH);
    adbus_in = b; wr = 1'b0;
    repeat (4) tick();
    wr = 1'b1;
    repeat (3) tick();
    if (accept) tx_q.push_back(b);
    check("wr_txe_pre0", txe, 1);
    check("wr_dout_valid", host_dout_valid, 1);
    check("wr_dout", host_dout, tx_q[0]);
    tick();
    check("wr_txe_pre1", txe, 1);
    tick();
    check("wr_txe_idle", txe, tx_q.size() == DEPTH);
  endtask

  task automatic host_pop();
    logic [7:0] exp;
    exp = tx_q.pop_front();
    check("pop_valid", host_dout_valid, 1);
    check("pop_data", host_dout, exp);
    host_dout_ready = 1'b1;
    tick();
    host_dout_ready = 1'b0;
    check("pop_valid_after", host_dout_valid, tx_q.size() != 0);
  endtask

`ifdef FTDI_ECHO_EN
  bit dout_seen = 1'b0;
  always @(negedge clock) if (host_dout_valid !== 1'b0) dout_seen = 1'b1;
`endif

  initial begin
    do_reset();
`ifdef FTDI_ECHO_EN
    adbus_in = 8'h5A; wr = 1'b0;
    repeat (4) tick();
    wr = 1'b1;
    repeat (4) tick();
    rx_q.push_back(8'h5A);
    check("echo_rxf", rxf, 0);
    repeat (2) tick();
    check("echo_txe", txe, 0);
    rd_pulse();
    check("echo_dout_never", dout_seen, 0);
    check("echo_dout_zero", host_dout, 0);
    check("echo_perr", proto_err, 0);
`else
    // single host byte read back over the rd strobe
    host_push(8'h3C);
    rd_pulse();

    // single wr byte seen by the host
    wr_pulse(8'hA5);
    host_pop();

    // fill the TX buffer, overflow attempt, drain in order
    for (int i = 0; i < DEPTH; i++) wr_pulse(8'(i));
    check("full_txe", txe, 1);
    check("full_perr0", proto_err, 0);
    wr_pulse(8'hEE);
    check("overflow_perr", proto_err, 1);
    for (int i = 0; i < DEPTH; i++) host_pop();
    check("drained_valid", host_dout_valid, 0);
    check("drained_txe", txe, 0);

    // rd while the RX buffer is empty
    do_reset();
    rd = 1'b0; oe_seen = 1'b0;
    repeat (8) begin tick(); if (adbus_oe) oe_seen = 1'b1; end
    rd = 1'b1;
    repeat (4) tick();
    check("empty_rd_oe", oe_seen, 0);
    check("empty_rd_perr", proto_err, 1);
    check("empty_rd_rxf", rxf, 1);
    host_push(8'h77);
    rd_pulse();

    // reset while the bus is driven
    do_reset();
    host_push(8'h99);
    rd = 1'b0; oe_seen = 1'b0;
    for (int n = 0; n < 6 && !oe_seen; n++) begin tick(); oe_seen = adbus_oe; end
    check("drive_reached", oe_seen, 1);
    #2 reset = 1'b1;
    #1 check("async_oe_release", adbus_oe, 0);
    check("async_rxf", rxf, 1);
    rd = 1'b1;
    repeat (2) tick();
    reset = 1'b0;
    rx_q.delete();
    tick();
    check("rel_rxf", rxf, 1);
    check("rel_txe", txe, 0);
    check("rel_perr", proto_err, 0);
    check("rel_din_ready", host_din_ready, 1);

    // rd and wr low together: flagged, yet both transfers complete
    host_push(8'h42);
    adbus_in = 8'h24; rd = 1'b0; wr = 1'b0;
    repeat (6) tick();
    check("both_low_perr", proto_err, 1);
    check("both_low_oe", adbus_oe, 1);
    check("both_low_data", adbus_out, 8'h42);
    rd = 1'b1; wr = 1'b1;
    repeat (8) tick();
    void'(rx_q.pop_front());
    tx_q.push_back(8'h24);
    check("both_low_rxf", rxf, 1);
    host_pop();

    // random traffic against the queue models
    do_reset();
    for (int i = 0; i < 48; i++) begin
      case ($urandom_range(0, 3))
        0: if (rx_q.size() < DEPTH) host_push(8'($urandom));
        1: if (rx_q.size() > 0) rd_pulse();
        2: if (tx_q.size() < DEPTH) wr_pulse(8'($urandom));
        default: if (tx_q.size() > 0) host_pop();
      endcase
    end
    while (rx_q.size() > 0) rd_pulse();
    while (tx_q.size() > 0) host_pop();
    check("random_perr", proto_err, 0);
    check("random_rxf", rxf, 1);
    check("random_valid", host_dout_valid, 0);
`endif
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
